// File: rtl/ins_mem_arbitrated_pkg.sv
// Shared defaults and helpers for the arbitrated instruction memory.
// Imported by the arbiter and the memory top.
package ins_mem_arbitrated_pkg;

    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_DEPTH      = 4096;
    localparam int DEF_CORES      = 4;

    // Index width that stays legal when only one core is present
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ins_mem_arbitrated_if.sv
// Loader write port plus packed per-core fetch bus of the shared instruction memory.
// Core i occupies slice [i*W +: W] of every packed per-core vector.
interface ins_mem_arbitrated_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int CORES      = 4
);
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       data_in;
    logic [CORES-1:0]            rd_req;
    logic [CORES*ADDR_WIDTH-1:0] rd_addr;
    logic [CORES-1:0]            rd_gnt;
    logic [CORES-1:0]            rd_valid;
    logic [CORES*DATA_WIDTH-1:0] data_out;

    modport master (
        output wr_en, wr_addr, data_in, rd_req, rd_addr,
        input  rd_gnt, rd_valid, data_out
    );

    modport slave (
        input  wr_en, wr_addr, data_in, rd_req, rd_addr,
        output rd_gnt, rd_valid, data_out
    );
endinterface

// File: rtl/ins_mem_arbitrated_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the pointer, wrapping,
// and moves the pointer just past the winner whenever a grant is issued.
module rr_arbiter
    import ins_mem_arbitrated_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_reg) + k) % N);
            if (!found && enable && req[idx]) begin
                found      = 1'b1;
                winner     = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (found) begin
            ptr_next = (int'(winner) == N - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/ins_mem_arbitrated.sv
// Shared instruction memory: one synchronous read port shared by CORES fetch ports via
// round-robin, same-address requests merged into one broadcast read; loader writes win.
module ins_mem_arbitrated
    import ins_mem_arbitrated_pkg::*;
#(
    parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int    DEPTH      = DEF_DEPTH,
    parameter int    ADDR_WIDTH = $clog2(DEPTH),
    parameter int    CORES      = DEF_CORES,
    parameter string INIT_FILE  = ""
) (
    input logic                clk,
    input logic                rst_n,
    ins_mem_arbitrated_if.slave bus
);
    localparam int IW = idx_width(CORES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_arr [CORES];
    logic [DATA_WIDTH-1:0] hold_reg [CORES];
    logic [CORES-1:0]      arb_grant;
    logic [CORES-1:0]      gnt;
    logic [CORES-1:0]      valid_reg;
    logic [IW-1:0]         winner;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  any_grant;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  addr_ok_reg;
    logic [DATA_WIDTH-1:0] read_word;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < (ADDR_WIDTH + 1)'(DEPTH);
    endfunction

    rr_arbiter #(.N(CORES)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.rd_req),
        .enable (~bus.wr_en),
        .grant  (arb_grant),
        .winner (winner)
    );

    assign any_grant = |arb_grant;
    assign win_addr  = addr_arr[winner];

    always_ff @(posedge clk) begin
        if (bus.wr_en && in_range(bus.wr_addr)) begin
            mem[bus.wr_addr] <= bus.data_in;
        end
    end

    // Plain registered read keeps the array mappable to block RAM
    always_ff @(posedge clk) begin
        if (any_grant) begin
            rd_data_reg <= mem[win_addr];
            addr_ok_reg <= in_range(win_addr);
        end
    end

    assign read_word = addr_ok_reg ? rd_data_reg : '0;

    genvar gi;
    generate
        for (gi = 0; gi < CORES; gi++) begin : g_core
            assign addr_arr[gi] = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            // Winner matches its own address, so this also covers the arbiter's pick
            assign gnt[gi] = any_grant & bus.rd_req[gi] & (addr_arr[gi] == win_addr);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    hold_reg[gi]  <= '0;
                end else begin
                    valid_reg[gi] <= gnt[gi];
                    if (valid_reg[gi]) begin
                        hold_reg[gi] <= read_word;
                    end
                end
            end

            // Fresh RAM word during the valid cycle, captured copy afterwards
            assign bus.data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
                valid_reg[gi] ? read_word : hold_reg[gi];
        end
    endgenerate

    assign bus.rd_gnt   = gnt;
    assign bus.rd_valid = valid_reg;

endmodule

// File: tb/tb_ins_mem_arbitrated.sv
// Directed bench for the arbitrated instruction memory: grants checked in the request cycle,
// read data checked one cycle later against a scoreboard fed from a reference memory.
module tb_ins_mem_arbitrated;
    localparam int DW = 12;
    localparam int AW = 12;
    localparam int NC = 4;

    typedef struct {
        int            core;
        logic [DW-1:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ins_mem_arbitrated_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CORES(NC)) bus ();

    ins_mem_arbitrated #(.DATA_WIDTH(DW), .DEPTH(4096), .ADDR_WIDTH(AW), .CORES(NC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_step = 0;
    sb_t           sb_q[$];
    logic [DW-1:0] model_mem [int];
    logic [NC*DW-1:0] model_dout = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, n_step, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then advance
    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NC-1:0] req,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                        input logic [NC-1:0] exp_gnt, input logic rst_after);
        logic [AW-1:0] addrs [NC];
        logic [NC-1:0] exp_valid;
        sb_t           e;
        addrs[0] = a0; addrs[1] = a1; addrs[2] = a2; addrs[3] = a3;
        bus.wr_en   = w;
        bus.wr_addr = wa;
        bus.data_in = wd;
        bus.rd_req  = req;
        bus.rd_addr = {a3, a2, a1, a0};
        n_step++;
        @(negedge clk);
        exp_valid = '0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_valid[e.core] = 1'b1;
            model_dout[e.core*DW +: DW] = e.data;
        end
        check("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
        check("data_out", 64'(bus.data_out), 64'(model_dout));
        check("rd_gnt", 64'(bus.rd_gnt), 64'(exp_gnt));
        $display("step %0d: wr=%0b req=%b gnt=%b valid=%b dout=%h", n_step, w, req,
                 bus.rd_gnt, bus.rd_valid, bus.data_out);
        for (int i = 0; i < NC; i++) begin
            if (exp_gnt[i]) begin
                e.core = i;
                e.data = model_mem.exists(int'(addrs[i])) ? model_mem[int'(addrs[i])] : 'x;
                sb_q.push_back(e);
            end
        end
        if (rst_after) begin
            rst_n      = 1'b0;
            bus.rd_req = '0;
            bus.wr_en  = 1'b0;
            sb_q.delete();
            model_dout = '0;
        end
        @(posedge clk);
        if (w && !rst_after) model_mem[int'(wa)] = wd;
        #1;
        if (rst_after) rst_n = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        step(1'b1, wa, wd, '0, '0, '0, '0, '0, 4'b0000, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, '0, '0, '0, '0, 4'b0000, 1'b0);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.data_in = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(bus.rd_valid), 64'(0));
        check("reset_dout", 64'(bus.data_out), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Loader writes, then back-to-back fetches by core0
        wr(12'h010, 12'hA5A);
        wr(12'h011, 12'h123);
        step(1'b0, '0, '0, 4'b0001, 12'h010, '0, '0, '0, 4'b0001, 1'b0);
        step(1'b0, '0, '0, 4'b0001, 12'h011, '0, '0, '0, 4'b0001, 1'b0);
        idle();

        // Same address from all cores: one read broadcast to everyone
        wr(12'h020, 12'h7FF);
        step(1'b0, '0, '0, 4'b1111, 12'h020, 12'h020, 12'h020, 12'h020, 4'b1111, 1'b0);
        idle();

        // Distinct addresses, continuous requests from a fresh pointer
        wr(12'h100, 12'h001);
        wr(12'h101, 12'h002);
        wr(12'h102, 12'h003);
        wr(12'h103, 12'h004);
        step(1'b0, '0, '0, 4'b0000, '0, '0, '0, '0, 4'b0000, 1'b1);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0001, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0010, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0100, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b1000, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0001, 1'b0);
        step(1'b0, '0, '0, 4'b1111, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0010, 1'b0);

        // Pointer is 2 here; core0 wins from the wrap, leaving the pointer at 1
        step(1'b0, '0, '0, 4'b0001, 12'h100, '0, '0, '0, 4'b0001, 1'b0);
        // Write blocks cores 1,2; then core1 wins and sees the new word
        step(1'b1, 12'h200, 12'h5C3, 4'b0110, '0, 12'h200, 12'h101, '0, 4'b0000, 1'b0);
        step(1'b0, '0, '0, 4'b0110, '0, 12'h200, 12'h101, '0, 4'b0010, 1'b0);
        step(1'b0, '0, '0, 4'b0100, '0, '0, 12'h101, '0, 4'b0100, 1'b0);
        idle();

        // Reset during an in-flight read drops it and clears the pointer
        step(1'b0, '0, '0, 4'b0001, 12'h010, '0, '0, '0, 4'b0001, 1'b1);
        idle();
        step(1'b0, '0, '0, 4'b1001, 12'h010, '0, '0, 12'h011, 4'b0001, 1'b0);
        idle();

        // Core2 request blocked by a write, then withdrawn: nothing reaches it
        step(1'b1, 12'h031, 12'h0EE, 4'b0100, '0, '0, 12'h030, '0, 4'b0000, 1'b0);
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
